// File: rtl/cpu_param_pkg.sv
// cpu_param_pkg: shared constants and width helpers for the cpu_param core.
//   - 4-bit opcode encodings OP_NOP..OP_HALT (OP_CALL/OP_RET are only decoded
//     when CPU_PARAM_CALL_EN is defined)
//   - flag bit indices within the flag register
//   - rs_w()/instr_w() derive register-select and instruction widths
package cpu_param_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned FLAG_C    = 0;
  localparam int unsigned FLAG_Z    = 1;
  localparam int unsigned NUM_FLAGS = 2;

  // Register-select width; never narrower than one bit.
  function automatic int unsigned rs_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Instruction word: opcode | rd | rs | imm.
  function automatic int unsigned instr_w(input int unsigned data_w,
                                          input int unsigned num_regs);
    return OPCODE_W + 2 * rs_w(num_regs) + data_w;
  endfunction

endpackage

// File: rtl/cpu_param_alu.sv
// cpu_param_alu: combinational ALU for opcodes ADD/SUB/AND/OR/XOR.
//   op     in  4       opcode (other opcodes give result 0, c 0)
//   a, b   in  DATA_W  operands (a = R[rd], b = R[rs])
//   result out DATA_W  modulo-2**DATA_W result
//   c      out 1       carry (ADD) / borrow (SUB), 0 for logic ops
//   z      out 1       result == 0
module cpu_param_alu
  import cpu_param_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] sum;

  // Extra top bit of the widened sum is the carry out.
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/cpu_param.sv
// cpu_param: single-cycle fetch/decode/execute core with loadable program memory.
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous active-high reset
//   run        in   1        execute enable (0 = stall)
//   prog_we    in   1        program memory write strobe
//   prog_addr  in   ADDR_W   program write address
//   prog_data  in   INSTR_W  instruction word to write
//   out_data   out  DATA_W   value of the last OUT
//   out_valid  out  1        one-cycle pulse per executed OUT
//   halted     out  1        core is in HALT
//   pc_out     out  ADDR_W   current PC
// Optional macro CPU_PARAM_CALL_EN adds CALL (0xC) / RET (0xD) with a
// single-entry return register; without it those opcodes are NOPs.
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 run,
  input  logic                                 prog_we,
  input  logic [ADDR_W-1:0]                    prog_addr,
  input  logic [instr_w(DATA_W, NUM_REGS)-1:0] prog_data,
  output logic [DATA_W-1:0]                    out_data,
  output logic                                 out_valid,
  output logic                                 halted,
  output logic [ADDR_W-1:0]                    pc_out
);

  localparam int unsigned RS_W    = rs_w(NUM_REGS);
  localparam int unsigned INSTR_W = instr_w(DATA_W, NUM_REGS);
  localparam int unsigned DEPTH   = 2 ** ADDR_W;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d, pc_inc;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;
  logic [DATA_W-1:0]      out_data_d;
  logic                   out_valid_d;

  logic [INSTR_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]      regs [NUM_REGS];

  logic [INSTR_W-1:0]     instr;
  logic [3:0]             opcode;
  logic [RS_W-1:0]        rd, rs;
  logic [DATA_W-1:0]      imm;
  logic [ADDR_W-1:0]      target;

  logic                   reg_we;
  logic [DATA_W-1:0]      reg_wdata;

  logic [DATA_W-1:0]      alu_result;
  logic                   alu_c, alu_z;

`ifdef CPU_PARAM_CALL_EN
  logic [ADDR_W-1:0]      ret_q, ret_d;
`endif

  // Program memory: not reset, writable in any state.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Combinational fetch and field decode.
  assign instr  = mem[pc_q];
  assign opcode = instr[INSTR_W-1 -: OPCODE_W];
  assign rd     = instr[INSTR_W-OPCODE_W-1 -: RS_W];
  assign rs     = instr[INSTR_W-OPCODE_W-RS_W-1 -: RS_W];
  assign imm    = instr[DATA_W-1:0];
  assign target = imm[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  cpu_param_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (opcode),
    .a      (regs[rd]),
    .b      (regs[rs]),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  // Next-state / execute logic; everything holds unless running.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    reg_we      = 1'b0;
    reg_wdata   = '0;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
`ifdef CPU_PARAM_CALL_EN
    ret_d       = ret_q;
`endif
    if (state_q == ST_RUN && run) begin
      pc_d = pc_inc;
      case (opcode)
        OP_LDI: begin
          reg_we    = 1'b1;
          reg_wdata = imm;
        end
        OP_MOV: begin
          reg_we    = 1'b1;
          reg_wdata = regs[rs];
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          reg_we           = 1'b1;
          reg_wdata        = alu_result;
          flags_d[FLAG_C]  = alu_c;
          flags_d[FLAG_Z]  = alu_z;
        end
        OP_JMP: pc_d = target;
        OP_JZ:  if (flags_q[FLAG_Z]) pc_d = target;
        OP_JC:  if (flags_q[FLAG_C]) pc_d = target;
        OP_OUT: begin
          out_valid_d = 1'b1;
          out_data_d  = regs[rs];
        end
        OP_HALT: begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end
`ifdef CPU_PARAM_CALL_EN
        OP_CALL: begin
          ret_d = pc_inc;
          pc_d  = target;
        end
        OP_RET: pc_d = ret_q;
`endif
        default: ;
      endcase
    end
  end

  // Core state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      flags_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef CPU_PARAM_CALL_EN
  // Single-entry return address; a nested CALL overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ret_q <= '0;
    else       ret_q <= ret_d;
  end
`endif

  // Register file; reset drops any write of the aborted instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[rd] <= reg_wdata;
    end
  end

  assign halted = (state_q == ST_HALT);
  assign pc_out = pc_q;

endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: self-checking bench for cpu_param (default parameters) with an
// instruction-level reference model. Honours CPU_PARAM_CALL_EN like the RTL.
module tb_cpu_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        halted;
  logic [3:0]  pc_out;

  int checks = 0;
  int failures = 0;

  cpu_param dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (instruction-level) ----------------
  logic [15:0] m_mem [16];
  logic [15:0] prog  [16];
  int m_pc, m_c, m_z, m_halt, m_od, m_ov, m_ret;
  int m_r [4];

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
    return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_c = 0; m_z = 0; m_halt = 0; m_od = 0; m_ov = 0; m_ret = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endfunction

  // One clock edge: execute the word fetched before the edge, then apply any write.
  function automatic void model_step(input logic r, input logic we,
                                     input logic [3:0] a, input logic [15:0] d);
    logic [15:0] w;
    int op, rd, rs, imm, tgt, npc, s;
    m_ov = 0;
    if (r && m_halt == 0) begin
      w   = m_mem[m_pc];
      op  = int'(w[15:12]);
      rd  = int'(w[11:10]);
      rs  = int'(w[9:8]);
      imm = int'(w[7:0]);
      tgt = imm % 16;
      npc = (m_pc + 1) % 16;
      case (op)
        1: m_r[rd] = imm;
        2: m_r[rd] = m_r[rs];
        3: begin s = m_r[rd] + m_r[rs]; m_c = (s > 255) ? 1 : 0; m_r[rd] = s % 256; end
        4: begin m_c = (m_r[rd] < m_r[rs]) ? 1 : 0; m_r[rd] = (m_r[rd] - m_r[rs] + 256) % 256; end
        5: begin m_r[rd] = m_r[rd] & m_r[rs]; m_c = 0; end
        6: begin m_r[rd] = m_r[rd] | m_r[rs]; m_c = 0; end
        7: begin m_r[rd] = m_r[rd] ^ m_r[rs]; m_c = 0; end
        8: npc = tgt;
        9: if (m_z != 0) npc = tgt;
        10: if (m_c != 0) npc = tgt;
        11: begin m_od = m_r[rs]; m_ov = 1; end
        15: begin m_halt = 1; npc = m_pc; end
`ifdef CPU_PARAM_CALL_EN
        12: begin m_ret = (m_pc + 1) % 16; npc = tgt; end
        13: npc = m_ret;
`endif
        default: ;
      endcase
      if (op >= 3 && op <= 7) m_z = (m_r[rd] == 0) ? 1 : 0;
      m_pc = npc;
    end
    if (we) m_mem[a] = d;
  endfunction

  function automatic logic [13:0] model_obs();
    return {4'(m_pc), 1'(m_halt), 1'(m_ov), 8'(m_od)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = enc(15, 0, 0, 0);
  endtask

  // Hold reset, load prog[] through the write port, release reset.
  task automatic reset_and_load();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; prog_we = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
      @(posedge clk);
      m_mem[i] = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0; reset = 1'b0;
  endtask

  task automatic cycle(input logic r, input logic we, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    run = r; prog_we = we; prog_addr = a; prog_data = d;
    @(posedge clk);
    model_step(r, we, a, d);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++;
    if ({pc_out, halted, out_valid, out_data} !== 14'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {pc_out, halted, out_valid, out_data}, 14'h0);
    end
  endtask

  // ADD with carry out: 250+10 -> 4, C=1 (JC taken), Z=0 (JZ not taken).
  task automatic test_add_carry();
    int pulses = 0;
    clear_prog();
    prog[0] = enc(1, 0, 0, 250);
    prog[1] = enc(1, 1, 0, 10);
    prog[2] = enc(3, 0, 1, 0);
    prog[3] = enc(11, 0, 0, 0);
    prog[4] = enc(9, 0, 0, 8);
    prog[5] = enc(10, 0, 0, 7);
    reset_and_load();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      cycle(1'b1, 1'b0, 4'd0, 16'd0);
      checks++;
      if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
        failures++;
        $display("FAIL add_carry cyc=%0d got=%h exp=%h", cyc, {pc_out, halted, out_valid, out_data}, model_obs());
      end
      if (out_valid === 1'b1) pulses++;
      if (cyc == 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd4) begin
          failures++;
          $display("FAIL add_out4 got valid=%b data=%0d exp valid=1 data=4", out_valid, out_data);
        end
      end
    end
    checks++;
    if (halted !== 1'b1 || pc_out !== 4'd7 || pulses != 1) begin
      failures++;
      $display("FAIL add_flags got halted=%b pc=%0d pulses=%0d exp halted=1 pc=7 pulses=1", halted, pc_out, pulses);
    end
  endtask

  task automatic test_sub_jz_halt();
    int pulses = 0;
    clear_prog();
    prog[0] = enc(1, 0, 0, 5);
    prog[1] = enc(1, 1, 0, 5);
    prog[2] = enc(4, 0, 1, 0);
    prog[3] = enc(9, 0, 0, 6);
    prog[4] = enc(11, 0, 1, 0);
    prog[5] = enc(0, 0, 0, 0);
    reset_and_load();
    for (int cyc = 1; cyc <= 15; cyc++) begin
      cycle(1'b1, 1'b0, 4'd0, 16'd0);
      checks++;
      if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
        failures++;
        $display("FAIL sub_jz cyc=%0d got=%h exp=%h", cyc, {pc_out, halted, out_valid, out_data}, model_obs());
      end
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (halted !== 1'b1 || pc_out !== 4'd6 || pulses != 0) begin
      failures++;
      $display("FAIL sub_jz_halt got halted=%b pc=%0d pulses=%0d exp halted=1 pc=6 pulses=0", halted, pc_out, pulses);
    end
  endtask

  // Counting loop wraps at 8 bits; 3-cycle stall in the middle.
  task automatic test_loop_stall();
    int exp_out = 2;
    int pulses = 0;
    logic [3:0] pc_hold;
    clear_prog();
    prog[0] = enc(1, 0, 0, 1);
    prog[1] = enc(1, 1, 0, 1);
    prog[2] = enc(3, 0, 1, 0);
    prog[3] = enc(11, 0, 0, 0);
    prog[4] = enc(8, 0, 0, 2);
    reset_and_load();
    for (int cyc = 1; cyc <= 2 + 3 * 258; cyc++) begin
      if (cyc >= 100 && cyc < 103) begin
        pc_hold = pc_out;
        cycle(1'b0, 1'b0, 4'd0, 16'd0);
        checks++;
        if (out_valid !== 1'b0 || pc_out !== pc_hold) begin
          failures++;
          $display("FAIL stall cyc=%0d got valid=%b pc=%0d exp valid=0 pc=%0d", cyc, out_valid, pc_out, pc_hold);
        end
      end else begin
        cycle(1'b1, 1'b0, 4'd0, 16'd0);
      end
      checks++;
      if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
        failures++;
        $display("FAIL loop cyc=%0d got=%h exp=%h", cyc, {pc_out, halted, out_valid, out_data}, model_obs());
      end
      if (out_valid === 1'b1) begin
        pulses++;
        checks++;
        if (out_data !== 8'(exp_out)) begin
          failures++;
          $display("FAIL loop_value n=%0d got=%0d exp=%0d", pulses, out_data, exp_out);
        end
        exp_out = (exp_out + 1) % 256;
      end
    end
    checks++;
    if (pulses < 256) begin
      failures++;
      $display("FAIL loop_pulses got=%0d exp>=256", pulses);
    end
  endtask

  // PC wraps 15 -> 0; then async reset while halted.
  task automatic test_wrap_reset();
    clear_prog();
    prog[0]  = enc(9, 0, 0, 4);
    prog[1]  = enc(1, 3, 0, 99);
    prog[2]  = enc(8, 0, 0, 14);
    prog[14] = enc(4, 1, 1, 0);
    prog[15] = enc(11, 0, 3, 0);
    reset_and_load();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      cycle(1'b1, 1'b0, 4'd0, 16'd0);
      checks++;
      if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
        failures++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, {pc_out, halted, out_valid, out_data}, model_obs());
      end
    end
    checks++;
    if (halted !== 1'b1 || pc_out !== 4'd4 || out_data !== 8'd99) begin
      failures++;
      $display("FAIL wrap_end got halted=%b pc=%0d data=%0d exp halted=1 pc=4 data=99", halted, pc_out, out_data);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pc_out, halted, out_valid, out_data} !== 14'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", {pc_out, halted, out_valid, out_data}, 14'h0);
    end
    clear_prog();
    for (int i = 0; i < 4; i++) prog[i] = enc(11, 0, i, 0);
    reset_and_load();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      cycle(1'b1, 1'b0, 4'd0, 16'd0);
      checks++;
      if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
        failures++;
        $display("FAIL regs_zero cyc=%0d got=%h exp=%h", cyc, {pc_out, halted, out_valid, out_data}, model_obs());
      end
      if (cyc <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
          failures++;
          $display("FAIL reg_reset r%0d got valid=%b data=%0d exp valid=1 data=0", cyc - 1, out_valid, out_data);
        end
      end
    end
  endtask

  // Overwrite mem[3] while it is being executed.
  task automatic test_self_modify();
    int outs [$];
    bit done = 0;
    clear_prog();
    prog[0] = enc(1, 0, 0, 1);
    prog[1] = enc(1, 1, 0, 2);
    prog[2] = enc(0, 0, 0, 0);
    prog[3] = enc(11, 0, 0, 0);
    prog[4] = enc(2, 0, 1, 0);
    prog[5] = enc(8, 0, 0, 2);
    reset_and_load();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (!done && m_pc == 3) begin
        cycle(1'b1, 1'b1, 4'd3, enc(11, 0, 3, 0));
        done = 1;
      end else begin
        cycle(1'b1, 1'b0, 4'd0, 16'd0);
      end
      checks++;
      if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
        failures++;
        $display("FAIL selfmod cyc=%0d got=%h exp=%h", cyc, {pc_out, halted, out_valid, out_data}, model_obs());
      end
      if (out_valid === 1'b1) outs.push_back(int'(out_data));
    end
    checks++;
    if (outs.size() < 2 || outs[0] != 1 || outs[1] != 0) begin
      failures++;
      $display("FAIL selfmod_seq got n=%0d first=%0d second=%0d exp first=1 second=0",
               outs.size(), (outs.size() > 0) ? outs[0] : -1, (outs.size() > 1) ? outs[1] : -1);
    end
  endtask

  task automatic test_call();
    int exp_pc;
    clear_prog();
    prog[0] = enc(1, 0, 0, 42);
    prog[1] = enc(1, 1, 0, 9);
    prog[2] = enc(12, 0, 0, 8);
    prog[3] = enc(11, 0, 1, 0);
    prog[8] = enc(11, 0, 0, 0);
    prog[9] = enc(13, 0, 0, 0);
`ifdef CPU_PARAM_CALL_EN
    exp_pc = 8;
`else
    exp_pc = 3;
`endif
    reset_and_load();
    for (int cyc = 1; cyc <= 9; cyc++) begin
      cycle(1'b1, 1'b0, 4'd0, 16'd0);
      checks++;
      if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
        failures++;
        $display("FAIL call cyc=%0d got=%h exp=%h", cyc, {pc_out, halted, out_valid, out_data}, model_obs());
      end
      if (cyc == 3) begin
        checks++;
        if (pc_out !== 4'(exp_pc)) begin
          failures++;
          $display("FAIL call_target got=%0d exp=%0d", pc_out, exp_pc);
        end
      end
    end
  endtask

  // Random programs, random stalls and random program writes.
  task automatic test_random();
    logic        r, we;
    logic [3:0]  a;
    logic [15:0] d;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++)
        prog[i] = enc(int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      prog[$urandom_range(8, 15)] = enc(15, 0, 0, 0);
      reset_and_load();
      for (int cyc = 1; cyc <= 150; cyc++) begin
        r  = ($urandom_range(0, 9) < 8);
        we = ($urandom_range(0, 19) == 0);
        a  = 4'($urandom_range(0, 15));
        d  = 16'($urandom);
        cycle(r, we, a, d);
        checks++;
        if ({pc_out, halted, out_valid, out_data} !== model_obs()) begin
          failures++;
          $display("FAIL random p=%0d cyc=%0d got=%h exp=%h", p, cyc, {pc_out, halted, out_valid, out_data}, model_obs());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_carry();
    test_sub_jz_halt();
    test_loop_stall();
    test_wrap_reset();
    test_self_modify();
    test_call();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
- Next-generation parametrised CPU: single-cycle fetch/decode/execute core with a register file, ALU flags, conditional jumps and a halt state.
- Program memory is loadable through a write port.
- Standalone top-level core; drives a registered output port with a valid strobe.

Parameters:
- DATA_W, 8, register/ALU/output width (>= ADDR_W, >= 2)
- ADDR_W, 4, PC width; program depth = 2**ADDR_W
- NUM_REGS, 4, register count (power of 2, >= 2); RS_W = clog2(NUM_REGS)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  execute enable; 0 = stall (no state change except program writes)
- prog_we  in  1  program memory write strobe
- prog_addr  in  ADDR_W  program write address
- prog_data  in  INSTR_W  instruction word; INSTR_W = 4+2*RS_W+DATA_W
- out_data  out  DATA_W  last OUT value
- out_valid  out  1  one-cycle pulse per OUT executed
- halted  out  1  core in HALT state
- pc_out  out  ADDR_W  current PC

Behaviour:
- Reset (async, active-high): pc=0, all regs=0, flags C=Z=0, out_data=0, out_valid=0, halted=0. Program memory is not reset.
- Instruction format: [INSTR_W-1:INSTR_W-4] opcode, then rd (RS_W), rs (RS_W), imm (DATA_W). Jump target = imm[ADDR_W-1:0].
- One instruction per cycle when run=1 and halted=0. Combinational fetch from mem[pc]; all results registered at the clock edge.
- Opcodes:
  - 0 NOP
  - 1 LDI: rd<=imm
  - 2 MOV: rd<=rs
  - 3 ADD: rd<=rd+rs; C=carry out; Z=(result==0)
  - 4 SUB: rd<=rd-rs; C=borrow (rd<rs unsigned); Z=(result==0)
  - 5 AND, 6 OR, 7 XOR: result to rd; Z updated; C cleared
  - 8 JMP: pc<=target
  - 9 JZ: if Z then pc<=target
  - A JC: if C then pc<=target
  - B OUT: out_data<=R[rs]; out_valid=1 for that cycle only
  - F HALT: halted<=1; pc holds
  - C, D, E: NOP (but see Optional Feature)
- Flags change only on opcodes 3-7.
- Arithmetic is modulo 2**DATA_W.
- Non-jump, non-taken-jump, and non-HALT opcodes: pc<=pc+1, wrapping from 2**ADDR_W-1 to 0.
- Conditional jumps test the flag values held before the current instruction.
- out_valid is 0 in every cycle without an executed OUT, including stall and halted cycles. out_data holds its value.
- HALT is exited only by reset.
- run=0: pc, regs, flags and halted hold.
- Program writes: mem[prog_addr]<=prog_data on any edge with prog_we=1, including during reset, stall or halt. A write to mem[pc] while running takes effect on the next fetch; the current cycle executes the old word.
- Reset mid-run aborts the current instruction. Any pending register write is discarded.

Optional Feature:
- Macro: CPU_PARAM_CALL_EN.
- Enabled:
  - C CALL: ret_reg<=pc+1 (wrapping); pc<=target
  - D RET: pc<=ret_reg
  - ret_reg is a single entry, reset to 0; a nested CALL overwrites it.
- Disabled: C and D are NOPs (pc+1); no ret_reg exists.

Decomposition:
- Package cpu_param_pkg: opcode constants (OP_NOP..OP_HALT), flag index constants, INSTR_W/RS_W derivation functions.
- One sub-module: cpu_param_alu, a combinational block (op, a, b -> result, c, z), parametrised by DATA_W.

Test Plan:
- Default params; program LDI R0,250; LDI R1,10; ADD R0,R1; OUT R0 -> out_data=4, out_valid pulse on cycle 4, C=1, Z=0.
- LDI R0,5; LDI R1,5; SUB R0,R1; JZ 6; OUT R1; HALT at 6 -> no out_valid; halted=1 with pc_out=6; pc stays 6 for 10 more cycles.
- Loop LDI R0,1; LDI R1,1; ADD R0,R1; OUT R0; JMP 2 -> outputs 2,3,...,255,0,1, wrapping at DATA_W. run=0 for 3 cycles mid-loop -> no pulses, state frozen.
- Sequential code at address 15 -> pc wraps to 0. Assert reset while halted -> halted=0, pc=0 immediately (async), regs=0.
- Write mem[3] while pc=3 and running -> old instruction executes; the new word executes on the next pass.
- CPU_PARAM_CALL_EN defined: CALL 8 at 2; at 8 OUT R0; RET -> returns to 3. Undefined: CALL acts as NOP (pc 2->3).
